// File: rtl/refcpu_pkg.sv
// Shared refcpu definitions: fetch FSM states, instruction bus request/response
// structs and the architectural reset vector.
package refcpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2,
        F_DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

endpackage

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage with redirect handling.
// Optional AdEL detection on misaligned PCs is enabled by REFCPU_FETCH_ADEL_EN.
module instr_fetch
    import refcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        iresp_addr_ok,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_ex
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  instr_q, instr_nxt;
    logic         aligned;
    ibus_req_t    req;
    ibus_resp_t   resp;

    assign resp = '{addr_ok: iresp_addr_ok, data_ok: iresp_data_ok, data: iresp_data};

`ifdef REFCPU_FETCH_ADEL_EN
    logic ex_q, ex_nxt;
    assign aligned  = (pc[1:0] == 2'b00);
    assign req.addr = pc;
    assign out_ex   = ex_q;
`else
    assign aligned  = 1'b1;
    assign req.addr = {pc[31:2], 2'b00};
    assign out_ex   = 1'b0;
`endif

    assign req.valid  = (state == F_REQ) && aligned && !reset;
    assign ireq_valid = req.valid;
    assign ireq_addr  = req.addr;
    assign out_valid  = (state == F_HOLD) && !reset;
    assign out_pc     = pc;
    assign out_instr  = instr_q;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr_q;
`ifdef REFCPU_FETCH_ADEL_EN
        ex_nxt    = ex_q;
`endif
        unique case (state)
            F_REQ: begin
                // A request accepted on the redirect cycle is still in flight on the bus.
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = (req.valid && resp.addr_ok) ? F_DROP : F_REQ;
                end else if (!aligned) begin
`ifdef REFCPU_FETCH_ADEL_EN
                    state_nxt = F_HOLD;
                    instr_nxt = 32'h0;
                    ex_nxt    = 1'b1;
`endif
                end else if (resp.addr_ok) begin
                    state_nxt = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = resp.data_ok ? F_REQ : F_DROP;
                end else if (resp.data_ok) begin
                    instr_nxt = resp.data;
`ifdef REFCPU_FETCH_ADEL_EN
                    ex_nxt    = 1'b0;
`endif
                    state_nxt = F_HOLD;
                end
            end
            F_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = F_REQ;
                end else if (out_ready) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = F_REQ;
                end
            end
            F_DROP: begin
                if (redirect_valid) pc_nxt = redirect_pc;
                if (resp.data_ok) state_nxt = F_REQ;
            end
            default: state_nxt = F_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= F_REQ;
            pc      <= RESET_PC;
            instr_q <= 32'h0;
`ifdef REFCPU_FETCH_ADEL_EN
            ex_q    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            instr_q <= instr_nxt;
`ifdef REFCPU_FETCH_ADEL_EN
            ex_q    <= ex_nxt;
`endif
        end
    end

endmodule
